bpred_two_level_pht: RTL and testbench
======================================

Name: bpred_two_level_pht

Overview:
- Parametrised two-level adaptive branch predictor: global history register (GHR) combined with branch-PC bits indexes a table of saturating counters.
- Replaces the fixed 8-bit BHR × 8-bit PC table. Adds:
  - selectable index hashing (concatenate or XOR);
  - an internal speculative GHR with mispredict recovery;
  - a registered 1-cycle prediction port;
  - sequential table initialisation instead of a single-cycle clear.
- Sits between fetch (prediction request) and branch resolution (update).

Parameters:
- HIST_W, 8, GHR width in bits.
- PC_W, 8, number of PC index bits, taken from pc[PC_LSB+PC_W-1:PC_LSB].
- PC_LSB, 2, lowest PC bit used for indexing.
- CNT_W, 2, saturating counter width (≥1).
- CNT_INIT, 1, counter value written on initialisation (must be < 2^CNT_W).
- HASH, 0, index mode:
  - 0: idx = {ghr, pc_idx}, IDX_W = HIST_W+PC_W.
  - 1: idx = pc_idx ^ ghr_adj, IDX_W = PC_W. ghr_adj = ghr truncated or zero-extended to PC_W bits.

Derived: DEPTH = 2^IDX_W.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- ready  out  1  table initialised; requests accepted only when 1
- pred_req  in  1  prediction request
- pred_pc  in  32  branch PC to predict
- pred_valid  out  1  prediction result valid (1 cycle after accepted pred_req)
- pred_taken  out  1  predicted direction (counter MSB)
- pred_ghr  out  HIST_W  GHR value used for this prediction (checkpoint, returned at update)
- upd_valid  in  1  resolved-branch update
- upd_pc  in  32  PC of resolved branch
- upd_ghr  in  HIST_W  checkpoint pred_ghr returned from the prediction
- upd_taken  in  1  actual outcome
- upd_mispredict  in  1  predicted direction was wrong; restore GHR

Behaviour:
- Reset (rst=1, any state, including mid-initialisation): state=INIT, init_idx=0, ghr=0, ready=0, pred_valid=0, pred_taken=0, pred_ghr=0.
- INIT state:
  - Each cycle write CNT_INIT to entry init_idx, then init_idx++.
  - After writing entry DEPTH-1, go to RUN. ready=1 from the next cycle: exactly DEPTH cycles after rst deasserts.
  - pred_req and upd_valid are ignored; pred_valid stays 0.
- RUN state, prediction:
  - pred_req=1 at cycle N: index from pred_pc and the current ghr.
  - At cycle N+1: pred_valid=1, pred_taken=counter[CNT_W-1], pred_ghr=ghr value at N.
  - pred_valid=0 in any cycle without an accepted request.
- Speculative history: an accepted pred_req shifts the GHR: ghr <= {ghr[HIST_W-2:0], predicted bit}. The predicted bit is the counter MSB read at cycle N.
- Update (upd_valid=1):
  - Index computed from upd_pc and upd_ghr, never the live ghr.
  - Counter saturating ±1: upd_taken=1 increments unless at 2^CNT_W-1; upd_taken=0 decrements unless at 0.
  - Update writes take effect at the next clock edge.
- Recovery (upd_valid=1 and upd_mispredict=1): ghr <= {upd_ghr[HIST_W-2:0], upd_taken}. upd_mispredict is ignored when upd_valid=0.
- Simultaneous pred_req and mispredict update in the same cycle:
  - The prediction is still returned (pred_valid=1 next cycle, computed with the pre-restore ghr).
  - The GHR takes the recovery value; the speculative shift is discarded.
- Simultaneous pred_req and update to the same index: the prediction returns the pre-update counter value (read-old). The write still lands.
- Non-mispredict update with pred_req: the GHR follows only the speculative shift.
- HIST_W=1: the shift degenerates to ghr <= new bit.
- Only the selected PC bits enter the index. Other PC bits are don't-care (aliasing is permitted).

Test Plan (HIST_W=4, PC_W=4, HASH=0, CNT_W=2, CNT_INIT=1 unless stated):
- Init: deassert rst at cycle 0 -> ready=0 for cycles 0..255, ready=1 at cycle 256. pred_req during INIT -> pred_valid stays 0. Re-assert rst at cycle 100 -> init restarts; ready rises 256 cycles after the final deassert.
- Saturation: three upd_valid, upd_taken=1, upd_pc=0x10, upd_ghr=0 -> counter 1→2→3→3; predict pc 0x10 with ghr 0 -> pred_taken=1. Then four not-taken updates -> counter 0; pred_taken=0.
- Speculative GHR: with all counters at 1, issue 3 consecutive pred_req -> pred_ghr returns 0,0,0; internal ghr=0. Train entry {ghr=0, pc=0x4} to 3, then pred_req pc 0x4 -> next pred_ghr=0b0001.
- Recovery: ghr=0b0101, update with upd_mispredict=1, upd_ghr=0b0011, upd_taken=1 -> next pred_ghr=0b0111.
- Collision: same-cycle pred_req and taken update to the same index (counter 1) -> pred_taken=0 (old value); next prediction to that index -> pred_taken=1. Same-cycle pred_req and mispredict update -> pred_valid=1 next cycle, ghr equals the recovery value.
- HASH=1, PC_W=4: pc index 0b1010, ghr 0b0110 -> entry 0b1100 trained; confirm aliasing with pc index 0b0110, ghr 0b1010 gives the same prediction.

Source files
------------

// File: rtl/bpred_two_level_pht.sv
// Two-level adaptive branch predictor: a speculative global history register
// combined with branch-PC bits indexes a table of saturating counters.
// The table is filled with CNT_INIT one entry per cycle after reset; the
// predictor reports ready once every entry has been written.
module bpred_two_level_pht #(
    parameter int HIST_W   = 8,
    parameter int PC_W     = 8,
    parameter int PC_LSB   = 2,
    parameter int CNT_W    = 2,
    parameter int CNT_INIT = 1,
    parameter int HASH     = 0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              ready_o,
    input  logic              pred_req_i,
    input  logic [31:0]       pred_pc_i,
    output logic              pred_valid_o,
    output logic              pred_taken_o,
    output logic [HIST_W-1:0] pred_ghr_o,
    input  logic              upd_valid_i,
    input  logic [31:0]       upd_pc_i,
    input  logic [HIST_W-1:0] upd_ghr_i,
    input  logic              upd_taken_i,
    input  logic              upd_mispredict_i
);

    localparam int IDX_W = (HASH == 0) ? HIST_W + PC_W : PC_W;
    localparam int DEPTH = 1 << IDX_W;

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    init_idx_q, init_idx_d;
    logic [HIST_W-1:0]   ghr_q, ghr_d;
    logic                pred_valid_q, pred_valid_d;
    logic                pred_taken_q, pred_taken_d;
    logic [HIST_W-1:0]   pred_ghr_q, pred_ghr_d;
    logic [CNT_W-1:0]    pht_q [DEPTH];

    logic [PC_W-1:0]     pred_pc_idx, upd_pc_idx;
    logic [IDX_W-1:0]    pred_idx, upd_idx;
    logic [CNT_W-1:0]    pred_cnt, upd_cnt, upd_cnt_new;
    logic                pred_fire, upd_fire;
    logic                unused_pc_bits;

    // Table index: history above PC bits, or PC bits XOR history folded to PC_W.
    function automatic logic [IDX_W-1:0] calc_idx(input logic [PC_W-1:0] pc_idx,
                                                  input logic [HIST_W-1:0] g);
        logic [IDX_W-1:0] idx;
        idx = '0;
        if (HASH == 0) begin
            idx = IDX_W'({g, pc_idx});
        end else begin
            for (int i = 0; i < PC_W; i++) begin
                idx[i] = pc_idx[i] ^ ((i < HIST_W) ? g[i % HIST_W] : 1'b0);
            end
        end
        return idx;
    endfunction

    // Shift a new outcome into the history; degenerates to a plain load for HIST_W=1.
    function automatic logic [HIST_W-1:0] shift_in(input logic [HIST_W-1:0] g,
                                                   input logic b);
        return HIST_W'({g, b});
    endfunction

    // Only the selected PC bits matter; the rest are sunk here.
    assign unused_pc_bits = ^{pred_pc_i, upd_pc_i};
    assign pred_pc_idx    = pred_pc_i[PC_LSB +: PC_W];
    assign upd_pc_idx     = upd_pc_i[PC_LSB +: PC_W];
    assign pred_idx       = calc_idx(pred_pc_idx, ghr_q);
    assign upd_idx        = calc_idx(upd_pc_idx, upd_ghr_i);
    assign pred_cnt       = pht_q[pred_idx];
    assign upd_cnt        = pht_q[upd_idx];
    assign pred_fire      = (state_q == S_RUN) && pred_req_i;
    assign upd_fire       = (state_q == S_RUN) && upd_valid_i;

    assign ready_o      = (state_q == S_RUN);
    assign pred_valid_o = pred_valid_q;
    assign pred_taken_o = pred_taken_q;
    assign pred_ghr_o   = pred_ghr_q;

    // Saturating +/-1 of the counter addressed by the resolved branch.
    always_comb begin
        upd_cnt_new = upd_cnt;
        if (upd_taken_i) begin
            if (upd_cnt != '1) upd_cnt_new = upd_cnt + 1'b1;
        end else begin
            if (upd_cnt != '0) upd_cnt_new = upd_cnt - 1'b1;
        end
    end

    // Next state: table sweep, speculative history, recovery and prediction port.
    always_comb begin
        state_d      = state_q;
        init_idx_d   = init_idx_q;
        ghr_d        = ghr_q;
        pred_valid_d = 1'b0;
        pred_taken_d = pred_taken_q;
        pred_ghr_d   = pred_ghr_q;
        case (state_q)
            S_INIT: begin
                init_idx_d = init_idx_q + 1'b1;
                if (init_idx_q == '1) state_d = S_RUN;
            end
            S_RUN: begin
                if (pred_fire) begin
                    pred_valid_d = 1'b1;
                    pred_taken_d = pred_cnt[CNT_W-1];
                    pred_ghr_d   = ghr_q;
                    ghr_d        = shift_in(ghr_q, pred_cnt[CNT_W-1]);
                end
                // Recovery wins over the speculative shift of a same-cycle request.
                if (upd_fire && upd_mispredict_i) begin
                    ghr_d = shift_in(upd_ghr_i, upd_taken_i);
                end
            end
            default: state_d = S_INIT;
        endcase
    end

    // Control and prediction registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_INIT;
            init_idx_q   <= '0;
            ghr_q        <= '0;
            pred_valid_q <= 1'b0;
            pred_taken_q <= 1'b0;
            pred_ghr_q   <= '0;
        end else begin
            state_q      <= state_d;
            init_idx_q   <= init_idx_d;
            ghr_q        <= ghr_d;
            pred_valid_q <= pred_valid_d;
            pred_taken_q <= pred_taken_d;
            pred_ghr_q   <= pred_ghr_d;
        end
    end

    // Counter table: init sweep writes, then resolved-branch updates (read-old on collision).
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == S_INIT) begin
                pht_q[init_idx_q] <= CNT_W'(CNT_INIT);
            end else if (upd_valid_i) begin
                pht_q[upd_idx] <= upd_cnt_new;
            end
        end
    end

endmodule

// File: tb/tb_bpred_two_level_pht.sv
// Bench for bpred_two_level_pht: a concatenating and an XOR-hashed instance
// share stimulus; an array model of the predictor is checked every cycle,
// plus hand-computed expectations at the interesting points.
module tb_bpred_two_level_pht;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pred_req = 1'b0;
    logic [31:0] pred_pc = '0;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = '0;
    logic [3:0]  upd_ghr = '0;
    logic        upd_taken = 1'b0;
    logic        upd_mispredict = 1'b0;

    logic       ready [2];
    logic       pred_valid [2];
    logic       pred_taken [2];
    logic [3:0] pred_ghr [2];

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    always #5 clk = ~clk;

    bpred_two_level_pht #(.HIST_W(4), .PC_W(4), .PC_LSB(2), .CNT_W(2), .CNT_INIT(1), .HASH(0)) dut0 (
        .clk(clk), .rst(rst), .ready_o(ready[0]),
        .pred_req_i(pred_req), .pred_pc_i(pred_pc),
        .pred_valid_o(pred_valid[0]), .pred_taken_o(pred_taken[0]), .pred_ghr_o(pred_ghr[0]),
        .upd_valid_i(upd_valid), .upd_pc_i(upd_pc), .upd_ghr_i(upd_ghr),
        .upd_taken_i(upd_taken), .upd_mispredict_i(upd_mispredict));

    bpred_two_level_pht #(.HIST_W(4), .PC_W(4), .PC_LSB(2), .CNT_W(2), .CNT_INIT(1), .HASH(1)) dut1 (
        .clk(clk), .rst(rst), .ready_o(ready[1]),
        .pred_req_i(pred_req), .pred_pc_i(pred_pc),
        .pred_valid_o(pred_valid[1]), .pred_taken_o(pred_taken[1]), .pred_ghr_o(pred_ghr[1]),
        .upd_valid_i(upd_valid), .upd_pc_i(upd_pc), .upd_ghr_i(upd_ghr),
        .upd_taken_i(upd_taken), .upd_mispredict_i(upd_mispredict));

    // Behavioural model, one set of state per instance.
    int m_pht [2][256];
    int m_ghr [2];
    int m_cnt [2];
    bit m_rdy [2];
    bit m_v   [2];
    int m_t   [2];
    int m_g   [2];
    int depth [2] = '{256, 16};

    function automatic int model_idx(input int k, input logic [31:0] pc, input int g);
        int p;
        p = int'((pc >> 2) % 16);
        if (k == 0) return g * 16 + p;
        return (p ^ g) % 16;
    endfunction

    task automatic model_step(input int k);
        int pidx, uidx, ng;
        if (rst) begin
            m_cnt[k] = 0; m_rdy[k] = 0; m_ghr[k] = 0;
            m_v[k] = 0; m_t[k] = 0; m_g[k] = 0;
        end else if (!m_rdy[k]) begin
            m_pht[k][m_cnt[k]] = 1;
            m_cnt[k]++;
            if (m_cnt[k] == depth[k]) m_rdy[k] = 1;
            m_v[k] = 0;
        end else begin
            ng = m_ghr[k];
            m_v[k] = 0;
            if (pred_req) begin
                pidx = model_idx(k, pred_pc, m_ghr[k]);
                m_v[k] = 1;
                m_t[k] = (m_pht[k][pidx] >= 2) ? 1 : 0;
                m_g[k] = m_ghr[k];
                ng = (m_ghr[k] * 2 + m_t[k]) % 16;
            end
            if (upd_valid) begin
                uidx = model_idx(k, upd_pc, int'(upd_ghr));
                if (upd_taken) begin
                    if (m_pht[k][uidx] < 3) m_pht[k][uidx]++;
                end else begin
                    if (m_pht[k][uidx] > 0) m_pht[k][uidx]--;
                end
                if (upd_mispredict) ng = (int'(upd_ghr) * 2 + int'(upd_taken)) % 16;
            end
            m_ghr[k] = ng;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("ready[%0d]", k), int'(ready[k]), int'(m_rdy[k]));
                chk($sformatf("pred_valid[%0d]", k), int'(pred_valid[k]), int'(m_v[k]));
                chk($sformatf("pred_taken[%0d]", k), int'(pred_taken[k]), m_t[k]);
                chk($sformatf("pred_ghr[%0d]", k), int'(pred_ghr[k]), m_g[k]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
    endtask

    task automatic do_pred(input logic [31:0] pc);
        pred_req = 1'b1; pred_pc = pc;
        tick();
        pred_req = 1'b0;
    endtask

    task automatic do_upd(input logic [31:0] pc, input logic [3:0] g, input logic t, input logic m);
        upd_valid = 1'b1; upd_pc = pc; upd_ghr = g; upd_taken = t; upd_mispredict = m;
        tick();
        upd_valid = 1'b0; upd_mispredict = 1'b0;
    endtask

    initial begin
        // Reset, then abort an initialisation part-way; requests during init are ignored.
        pred_req = 1'b1;
        tick();
        tick();
        chk_en = 1'b1;
        chk("reset ready", int'(ready[0]), 0);
        chk("reset pred_taken", int'(pred_taken[0]), 0);
        chk("reset pred_ghr", int'(pred_ghr[0]), 0);
        rst = 1'b0;
        for (int c = 0; c < 100; c++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("ready cycle 0", int'(ready[0]), 0);
        for (int c = 1; c <= 256; c++) begin
            tick();
            if (c == 255) begin
                chk("ready cycle 255", int'(ready[0]), 0);
                chk("pred_valid in init", int'(pred_valid[0]), 0);
            end
            if (c == 256) begin
                chk("ready cycle 256", int'(ready[0]), 1);
                pred_req = 1'b0;
            end
        end

        // Speculative history with all counters weakly not-taken.
        for (int i = 0; i < 3; i++) begin
            do_pred(32'h0);
            chk("spec pred_ghr zero", int'(pred_ghr[0]), 0);
            chk("spec pred_taken zero", int'(pred_taken[0]), 0);
        end

        // Saturate up, predict taken, and see the taken bit shift into history.
        for (int i = 0; i < 3; i++) do_upd(32'h10, 4'h0, 1'b1, 1'b0);
        do_pred(32'h10);
        chk("sat taken", int'(pred_taken[0]), 1);
        chk("sat pred_ghr", int'(pred_ghr[0]), 0);
        do_pred(32'h10);
        chk("shifted pred_ghr", int'(pred_ghr[0]), 1);
        chk("ghr1 entry taken", int'(pred_taken[0]), 0);

        // Saturate down; last update also restores history to zero.
        for (int i = 0; i < 3; i++) do_upd(32'h10, 4'h0, 1'b0, 1'b0);
        do_upd(32'h10, 4'h0, 1'b0, 1'b1);
        do_pred(32'h10);
        chk("sat not taken", int'(pred_taken[0]), 0);
        chk("restored pred_ghr", int'(pred_ghr[0]), 0);

        // Recovery: history 0101, then mispredict with checkpoint 0011 taken.
        do_upd(32'h100, 4'b0010, 1'b1, 1'b1);
        do_upd(32'h100, 4'b0011, 1'b1, 1'b1);
        do_pred(32'h0);
        chk("recovery pred_ghr", int'(pred_ghr[0]), 7);

        // Collision: same-cycle predict and taken update to entry {1110, pc idx 2}.
        pred_req = 1'b1; pred_pc = 32'h8;
        upd_valid = 1'b1; upd_pc = 32'h8; upd_ghr = 4'b1110; upd_taken = 1'b1; upd_mispredict = 1'b0;
        tick();
        pred_req = 1'b0; upd_valid = 1'b0;
        chk("collision read-old", int'(pred_taken[0]), 0);
        chk("collision pred_ghr", int'(pred_ghr[0]), 14);
        do_upd(32'h3C, 4'b0111, 1'b0, 1'b1);
        do_pred(32'h8);
        chk("collision write landed", int'(pred_taken[0]), 1);
        chk("collision ghr restored", int'(pred_ghr[0]), 14);

        // Same-cycle predict and mispredict: prediction uses old history, recovery wins.
        pred_req = 1'b1; pred_pc = 32'h0;
        upd_valid = 1'b1; upd_pc = 32'h3C; upd_ghr = 4'b1001; upd_taken = 1'b1; upd_mispredict = 1'b1;
        tick();
        pred_req = 1'b0; upd_valid = 1'b0; upd_mispredict = 1'b0;
        chk("pred+mispredict valid", int'(pred_valid[0]), 1);
        chk("pred+mispredict old ghr", int'(pred_ghr[0]), 13);
        do_pred(32'h0);
        chk("pred+mispredict new ghr", int'(pred_ghr[0]), 3);

        // XOR hashing: train pc 1010 ^ ghr 0110 = entry 1100, then hit it via the alias.
        do_upd(32'h28, 4'b0110, 1'b1, 1'b0);
        do_upd(32'h28, 4'b0110, 1'b1, 1'b0);
        do_upd(32'h0, 4'b0101, 1'b0, 1'b1);
        do_pred(32'h18);
        chk("hash alias taken", int'(pred_taken[1]), 1);
        chk("hash alias ghr", int'(pred_ghr[1]), 10);
        do_upd(32'h0, 4'b0011, 1'b0, 1'b1);
        do_pred(32'h28);
        chk("hash direct taken", int'(pred_taken[1]), 1);

        tick();
        tick();
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
